// File: rtl/uart_pkg.sv
// Shared FSM state encoding and parity mode codes for the UART receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        CLEANUP = 3'd5
    } uart_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input, reset to RST_VAL.
// Latency: 2 clk cycles.
// Backpressure: none, free-running.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver (data width, parity, stop bits); UART_RX_MAJORITY_EN selects 2-of-3 sampling.
// Latency: rx_dv one cycle after the last stop-bit sample (+2 synchroniser cycles from the pad).
// Backpressure: none; rx_dv is a one-cycle pulse and the consumer must take it.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 rx_dv,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int BW  = $clog2(DATA_BITS + 1);
    localparam int MID = (CLKS_PER_BIT - 1) / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int SAMPLE_OFS = 1;
`else
    localparam int SAMPLE_OFS = 0;
`endif
    localparam logic [CW-1:0] START_CNT = CW'(MID + SAMPLE_OFS);
    localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);

    logic rx_sync;
    logic sample;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_serial),
        .q     (rx_sync)
    );

`ifdef UART_RX_MAJORITY_EN
    // Decision is taken one count late so the window straddles the bit centre.
    logic [1:0] hist_q, hist_d;
    always_comb hist_d = {hist_q[0], rx_sync};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist_q <= 2'b11;
        else        hist_q <= hist_d;
    end
    assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_sync) | (hist_q[0] & rx_sync);
`else
    assign sample = rx_sync;
`endif

    uart_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_acc_q, par_acc_d;
    logic                 frm_acc_q, frm_acc_d;
    logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
    logic                 rx_dv_q, rx_dv_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 tick;

    assign tick = (cnt_q == LAST_CNT);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        par_acc_d    = par_acc_q;
        frm_acc_d    = frm_acc_q;
        rx_byte_d    = rx_byte_q;
        rx_dv_d      = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rx_sync) begin
                    state_d   = START;
                    par_acc_d = 1'b0;
                    frm_acc_d = 1'b0;
                end
            end
            START: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == START_CNT) begin
                    cnt_d   = '0;
                    state_d = sample ? IDLE : DATA;
                end
            end
            DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (tick) begin
                    cnt_d   = '0;
                    shift_d = {sample, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BW'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                cnt_d = cnt_q + 1'b1;
                if (tick) begin
                    cnt_d     = '0;
                    par_acc_d = (PARITY_MODE == PARITY_ODD) ? (sample == ^shift_q)
                                                            : (sample != ^shift_q);
                    state_d   = STOP;
                end
            end
            STOP: begin
                cnt_d = cnt_q + 1'b1;
                if (tick) begin
                    cnt_d = '0;
                    bit_d = bit_q + 1'b1;
                    if (!sample) frm_acc_d = 1'b1;
                    if (bit_q == BW'(STOP_BITS - 1)) begin
                        state_d      = CLEANUP;
                        rx_dv_d      = 1'b1;
                        rx_byte_d    = shift_q;
                        parity_err_d = par_acc_q;
                        frame_err_d  = frm_acc_q | ~sample;
                    end
                end
            end
            CLEANUP: begin
                // A framing error may mean a break; hold off until the line idles.
                if (!frame_err_q || rx_sync) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            par_acc_q    <= 1'b0;
            frm_acc_q    <= 1'b0;
            rx_byte_q    <= '0;
            rx_dv_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            par_acc_q    <= par_acc_d;
            frm_acc_q    <= frm_acc_d;
            rx_byte_q    <= rx_byte_d;
            rx_dv_q      <= rx_dv_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign rx_byte    = rx_byte_q;
    assign rx_dv      = rx_dv_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign rx_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: four configurations (8N1, 8E1, 8N2, 7O2) driven with
// directed and $urandom frames; a monitor pops expected results whenever rx_dv pulses.
`timescale 1ns/1ps
module tb_uart_rx_param;

    localparam int CPB [4] = '{217, 217, 217, 16};
    localparam int DB  [4] = '{8, 8, 8, 7};
    localparam int PM  [4] = '{0, 1, 0, 2};
    localparam int SB  [4] = '{1, 1, 2, 2};

    typedef struct {
        int         idx;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ser [4];
    logic [8:0] ob  [4];
    logic       dv  [4];
    logic       pe  [4];
    logic       fe  [4];
    logic       bz  [4];
    logic [7:0] b0, b1, b2;
    logic [6:0] b3;

    exp_t sb [$];
    exp_t last_e [4];
    int   checks = 0;
    int   errors = 0;

    always #20 clk = ~clk;

    uart_rx_param #(.CLKS_PER_BIT(217), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_d0 (
        .clk(clk), .rst_n(rst_n), .rx_serial(ser[0]), .rx_byte(b0), .rx_dv(dv[0]),
        .parity_err(pe[0]), .frame_err(fe[0]), .rx_busy(bz[0]));
    uart_rx_param #(.CLKS_PER_BIT(217), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .rx_serial(ser[1]), .rx_byte(b1), .rx_dv(dv[1]),
        .parity_err(pe[1]), .frame_err(fe[1]), .rx_busy(bz[1]));
    uart_rx_param #(.CLKS_PER_BIT(217), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .rx_serial(ser[2]), .rx_byte(b2), .rx_dv(dv[2]),
        .parity_err(pe[2]), .frame_err(fe[2]), .rx_busy(bz[2]));
    uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u_d3 (
        .clk(clk), .rst_n(rst_n), .rx_serial(ser[3]), .rx_byte(b3), .rx_dv(dv[3]),
        .parity_err(pe[3]), .frame_err(fe[3]), .rx_busy(bz[3]));

    assign ob[0] = {1'b0, b0};
    assign ob[1] = {1'b0, b1};
    assign ob[2] = {1'b0, b2};
    assign ob[3] = {2'b00, b3};

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0h required=%0h at %0t", name, idx, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every rx_dv pulse must match the oldest outstanding expected frame.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (dv[i]) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rx_dv", i, 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rx_dv_source", i, i, e.idx);
                    chk("rx_byte", i, ob[i], e.data);
                    chk("parity_err", i, pe[i], e.perr);
                    chk("frame_err", i, fe[i], e.ferr);
                end
            end
        end
    end

    // Drives one frame on line idx, then a two-bit idle gap. stop_low marks stop bits driven
    // low; extra_low extends a low final stop bit; glitch_c inverts one cycle of the frame.
    task automatic send(input int idx, input logic [8:0] data_in, input bit flip,
                        input logic [1:0] stop_low, input int extra_low,
                        input int glitch_c, input int exp_ovr);
        bit   q [$];
        exp_t e;
        logic [8:0] d;
        bit   want, pbit, ends_low;
        int   cpb, n, rel;
        cpb = CPB[idx];
        d = data_in & 9'((1 << DB[idx]) - 1);
        q.push_back(1'b0);
        for (int i = 0; i < DB[idx]; i++) q.push_back(d[i]);
        e.perr = 1'b0;
        if (PM[idx] != 0) begin
            want = (($countones(d) % 2) == 1) ^ (PM[idx] == 2);
            pbit = want ^ flip;
            q.push_back(pbit);
            e.perr = (pbit != want);
        end
        e.ferr = 1'b0;
        for (int s = 0; s < SB[idx]; s++) begin
            q.push_back(!stop_low[s]);
            if (stop_low[s]) e.ferr = 1'b1;
        end
        ends_low = stop_low[SB[idx]-1];
        if (ends_low) for (int i = 0; i < extra_low; i++) q.push_back(1'b0);
        e.idx  = idx;
        e.data = (exp_ovr >= 0) ? 9'(exp_ovr) : d;
        sb.push_back(e);
        n = q.size() * cpb;
        for (int c = 0; c < n; c++) begin
            ser[idx] = (c == glitch_c) ? !q[c / cpb] : q[c / cpb];
            tick();
        end
        if (ends_low) chk("busy_in_break", idx, bz[idx], 1);
        ser[idx] = 1'b1;
        rel = -1;
        for (int c = 0; c < 2 * cpb; c++) begin
            tick();
            if (rel < 0 && !bz[idx]) rel = c + 1;
        end
        if (ends_low) chk("break_release", idx, (rel > 0 && rel <= 8), 1);
        chk("busy_idle", idx, bz[idx], 0);
        chk("hold_byte", idx, ob[idx], e.data);
        chk("hold_perr", idx, pe[idx], e.perr);
        chk("hold_ferr", idx, fe[idx], e.ferr);
        last_e[idx] = e;
    endtask

    task automatic send_rand(input int idx);
        logic [1:0] sl;
        sl[0] = ($urandom_range(0, 3) == 0);
        sl[1] = ($urandom_range(0, 3) == 0);
        send(idx, 9'($urandom), ($urandom_range(0, 3) == 0), sl, $urandom_range(0, 1), -1, -1);
    endtask

    task automatic chk_zero(input int idx);
        chk("rst_rx_byte", idx, ob[idx], 0);
        chk("rst_rx_dv", idx, dv[idx], 0);
        chk("rst_parity_err", idx, pe[idx], 0);
        chk("rst_frame_err", idx, fe[idx], 0);
        chk("rst_rx_busy", idx, bz[idx], 0);
    endtask

    initial begin
        #3_500_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1);
    end

    initial begin
        int rel;
        bit pq [$];
        for (int i = 0; i < 4; i++) begin
            ser[i] = 1'b1;
            last_e[i] = '{idx: i, data: 9'd0, perr: 1'b0, ferr: 1'b0};
        end
        repeat (5) tick();
        for (int i = 0; i < 4; i++) chk_zero(i);
        rst_n = 1'b1;
        repeat (5) tick();

        // 8N1 basic frame
        send(0, 9'h3F, 1'b0, 2'b00, 0, -1, -1);

        // Reset in the middle of data bit 3 discards the partial frame
        pq.push_back(1'b0);
        for (int i = 0; i < 8; i++) pq.push_back(((8'hC3 >> i) & 8'h1) != 0);
        for (int c = 0; c < 4 * 217 + 100; c++) begin
            ser[0] = pq[c / 217];
            tick();
        end
        chk("busy_mid_frame", 0, bz[0], 1);
        #7 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) chk_zero(i);
        ser[0] = 1'b1;
        repeat (3) tick();
        #5 rst_n = 1'b1;
        repeat (5) tick();
        send(0, 9'h55, 1'b0, 2'b00, 0, -1, -1);

        // One-cycle high glitch at the sample point of data bit 2
`ifdef UART_RX_MAJORITY_EN
        send(0, 9'hF0, 1'b0, 2'b00, 0, 108 + 1 + 3 * 217, 9'hF0);
`else
        send(0, 9'hF0, 1'b0, 2'b00, 0, 108 + 1 + 3 * 217, 9'hF4);
`endif

        // Short low pulse is rejected as a false start
        ser[0] = 1'b0;
        repeat (50) tick();
        chk("busy_false_start", 0, bz[0], 1);
        ser[0] = 1'b1;
        rel = -1;
        for (int c = 0; c < 110; c++) begin
            tick();
            if (!bz[0]) begin
                rel = c + 1;
                break;
            end
        end
        chk("false_start_release", 0, (rel > 0), 1);
        repeat (2 * 217) tick();
        chk("false_start_hold", 0, ob[0], last_e[0].data);

        for (int i = 0; i < 3; i++) send_rand(0);

        // 8E1: 0xA5 has even ones, so a parity bit of 1 is wrong
        send(1, 9'hA5, 1'b1, 2'b00, 0, -1, -1);
        for (int i = 0; i < 3; i++) send_rand(1);

        // 8N2: second stop bit low and the line held low for a break
        send(2, 9'h81, 1'b0, 2'b10, 3, -1, -1);
        for (int i = 0; i < 3; i++) send_rand(2);

        for (int i = 0; i < 40; i++) send_rand(3);

        repeat (10) tick();
        chk("sb_drain", 0, sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
